// File: rtl/noc_vc_input_queue_pkg.sv
// Shared types and width helpers for the virtual-channel input queue.
// Flits use [0:PL-1] ordering so the valid flag sits in bit 0, the MSB.
package noc_queue_pkg;

    localparam int PL        = 16;
    localparam int VALID_BIT = 0;

    typedef logic [0:PL-1] flit_t;

    // A single VC still needs a one-bit select so the port never collapses to zero width.
    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/noc_vc_input_queue_if.sv
// Link-side and arbiter-side signals of the input queue.
// The master modport drives flits and pops; the slave modport is the queue itself.
interface noc_vc_input_queue_if
    import noc_queue_pkg::*;
#(
    parameter int PL_W   = PL,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = 2,
    parameter int VC_W   = vc_width(NUM_VC),
    parameter int CNT_W  = cnt_width(DEPTH)
);
    // No handshake beyond this: a push is data_in[0]=1, and the sender must respect
    // availability_signal or the flit is dropped and overflow_err is raised.
    logic [0:PL_W-1]                  data_in;
    logic [VC_W-1:0]                  vc_sel_in;
    logic [NUM_VC-1:0]                shift_signal;
    logic                             err_clr;
    logic [NUM_VC-1:0][0:PL_W-1]      data_out;
    logic [NUM_VC-1:0]                availability_signal;
    logic [NUM_VC-1:0][CNT_W-1:0]     count;
    logic [NUM_VC-1:0]                overflow_err;

    modport master (
        output data_in, vc_sel_in, shift_signal, err_clr,
        input  data_out, availability_signal, count, overflow_err
    );

    modport slave (
        input  data_in, vc_sel_in, shift_signal, err_clr,
        output data_out, availability_signal, count, overflow_err
    );

endinterface

// File: rtl/noc_vc_input_queue_lane.sv
// One virtual channel: a DEPTH-entry compacting shift queue with occupancy and a sticky
// overflow flag. Head is always entry 0; vacated entries are zeroed so an empty head reads 0.
module noc_vc_queue_lane
    import noc_queue_pkg::*;
#(
    parameter int PL_W  = PL,
    parameter int DEPTH = 4,
    parameter int CNT_W = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [0:PL_W-1]   flit_in,
    input  logic              err_clr,
    output logic [0:PL_W-1]   head,
    output logic              avail,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    logic [0:PL_W-1]  mem     [DEPTH];
    logic [0:PL_W-1]  mem_nxt [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ovf;
    logic             ovf_set;
    logic             pop_eff;
    logic             full;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign pop_eff = pop && (cnt != '0);

    always_comb begin
        mem_nxt = mem;
        cnt_nxt = cnt;
        ovf_set = 1'b0;
        if (pop_eff) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_nxt[i] = mem[i + 1];
            end
            mem_nxt[DEPTH-1] = '0;
            // A simultaneous push lands in the slot the shift just freed, so a full VC stays full.
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == cnt - CNT_W'(1)) mem_nxt[i] = flit_in;
                end
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
            end
        end else if (push) begin
            if (!full) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CNT_W'(i) == cnt) mem_nxt[i] = flit_in;
                end
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                ovf_set = 1'b1;
            end
        end
    end

    // State advances on the falling edge so the arbiter sees stable heads at the rising edge.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            mem <= mem_nxt;
            cnt <= cnt_nxt;
            if (ovf_set)      ovf <= 1'b1;
            else if (err_clr) ovf <= 1'b0;
        end
    end

    assign head     = mem[0];
    assign avail    = !full;
    assign count    = cnt;
    assign overflow = ovf;

endmodule

// File: rtl/noc_vc_input_queue.sv
// NoC router input buffer: NUM_VC independent compacting FIFOs between the link receiver
// and the arbiter. The top only steers incoming flits to a lane and fans out control.
module noc_vc_input_queue
    import noc_queue_pkg::*;
#(
    parameter int PL_W   = PL,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = 2,
    parameter int VC_W   = vc_width(NUM_VC),
    parameter int CNT_W  = cnt_width(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    noc_vc_input_queue_if.slave bus
);

    logic flit_valid;

    assign flit_valid = bus.data_in[VALID_BIT];

    for (genvar v = 0; v < NUM_VC; v++) begin : g_lane
        logic              push;
        logic [0:PL_W-1]   head;
        logic              avail;
        logic [CNT_W-1:0]  cnt;
        logic              ovf;

        // Select values with no matching lane never assert any push, so they drop silently.
        assign push = flit_valid && (bus.vc_sel_in == VC_W'(v));

        noc_vc_queue_lane #(
            .PL_W  (PL_W),
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push),
            .pop      (bus.shift_signal[v]),
            .flit_in  (bus.data_in),
            .err_clr  (bus.err_clr),
            .head     (head),
            .avail    (avail),
            .count    (cnt),
            .overflow (ovf)
        );

        assign bus.data_out[v]            = head;
        assign bus.availability_signal[v] = avail;
        assign bus.count[v]               = cnt;
        assign bus.overflow_err[v]        = ovf;
    end

endmodule
